// File: rtl/kids_pkg.sv
// Shared types and constants for the kids_n channel controllers.
package kids_pkg;

    typedef logic [1:0] kid_state_t;

    localparam kid_state_t KID_HUNGRY = 2'b01;
    localparam kid_state_t KID_FULL   = 2'b10;
    localparam kid_state_t KID_STUDY  = 2'b11;

    localparam int KID_CNT_W = 8;

endpackage

// File: rtl/kid_chan.sv
// One kid channel: hungry/full/study FSM with study down-counter and registered outputs.
//
// state  | meaning
// HUNGRY | requesting a meal; book ignored
// FULL   | fed, waiting for a book; meals rejected
// STUDY  | counting down STUDY_CYC cycles; meals rejected
// 2'b00  | illegal, recovers to HUNGRY
module kid_chan
    import kids_pkg::*;
#(
    parameter int STUDY_CYC = 3
) (
    input  logic clk,
    input  logic resetb,
    input  logic meal,
    input  logic book,
    output logic request,
    output logic study_done,
    output logic hungry
);

    localparam logic [KID_CNT_W-1:0] LOAD = KID_CNT_W'(STUDY_CYC - 1);
    localparam logic [KID_CNT_W-1:0] ONE  = KID_CNT_W'(1);

    kid_state_t             r_state;
    kid_state_t             w_next;
    logic [KID_CNT_W-1:0]   r_cnt;
    logic [KID_CNT_W-1:0]   w_cnt_next;
    logic                   r_request;
    logic                   r_study_done;

    // Counter is held at zero everywhere except while studying.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = '0;
        case (r_state)
            KID_HUNGRY: begin
                if (meal) w_next = KID_FULL;
            end
            KID_FULL: begin
                if (book) begin
                    w_next     = KID_STUDY;
                    w_cnt_next = LOAD;
                end
            end
            KID_STUDY: begin
                if (r_cnt != '0) w_cnt_next = r_cnt - ONE;
                else             w_next     = KID_HUNGRY;
            end
            default: w_next = KID_HUNGRY;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state      <= KID_HUNGRY;
            r_cnt        <= '0;
            r_request    <= 1'b0;
            r_study_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt_next;
            r_request    <= (w_next == KID_HUNGRY);
            r_study_done <= (r_state == KID_STUDY) && (r_cnt == '0);
        end
    end

    assign request    = r_request;
    assign study_done = r_study_done;
    assign hungry     = (r_state == KID_HUNGRY);

endmodule

// File: rtl/kids_n.sv
// N independent kid channels plus hungry popcount and optional waste counter.
// Define KIDS_WASTE_CNT_EN to build the saturating rejected-meal counter.
module kids_n
    import kids_pkg::*;
#(
    parameter int N         = 4,
    parameter int STUDY_CYC = 3
) (
    input  logic                     clk,
    input  logic                     resetb,
    input  logic [N-1:0]             meal,
    input  logic [N-1:0]             book,
    output logic [N-1:0]             request,
    output logic [N-1:0]             study_done,
    output logic [$clog2(N+1)-1:0]   hungry_cnt,
    output logic [7:0]               waste_cnt
);

    localparam int HC_W = $clog2(N+1);

    logic [N-1:0] w_hungry;

    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        kid_chan #(.STUDY_CYC(STUDY_CYC)) u_chan (
            .clk        (clk),
            .resetb     (resetb),
            .meal       (meal[gi]),
            .book       (book[gi]),
            .request    (request[gi]),
            .study_done (study_done[gi]),
            .hungry     (w_hungry[gi])
        );
    end

    always_comb begin
        hungry_cnt = '0;
        for (int i = 0; i < N; i++) hungry_cnt = hungry_cnt + HC_W'(w_hungry[i]);
    end

`ifdef KIDS_WASTE_CNT_EN
    logic [7:0] r_waste;
    logic [8:0] w_waste_sum;

    // A meal offered to any non-hungry channel is wasted.
    always_comb begin
        w_waste_sum = {1'b0, r_waste};
        for (int i = 0; i < N; i++) w_waste_sum = w_waste_sum + 9'(meal[i] & ~w_hungry[i]);
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)                     r_waste <= '0;
        else if (w_waste_sum > 9'd255)   r_waste <= 8'd255;
        else                             r_waste <= w_waste_sum[7:0];
    end

    assign waste_cnt = r_waste;
`else
    assign waste_cnt = '0;
`endif

endmodule

// File: tb/tb_kids_n.sv
// Self-checking bench for kids_n: directed vector table, corner sequences, random vs model.
module tb_kids_n;

    localparam int N  = 4;
    localparam int SC = 3;

    logic       clk = 1'b0;
    logic       resetb;
    logic [3:0] meal, book, request, study_done;
    logic [2:0] hungry_cnt;
    logic [7:0] waste_cnt;

    logic       meal1, book1, req1, sd1;
    logic [0:0] hc1;
    logic [7:0] waste1;

    int total = 0;
    int bad   = 0;

    int         ph[N];      // 0 hungry, 1 full, 1+e studying for e edges
    int         mwaste;
    logic       mvalid;
    logic [3:0] msd;

    kids_n #(.N(N), .STUDY_CYC(SC)) dut (
        .clk(clk), .resetb(resetb), .meal(meal), .book(book),
        .request(request), .study_done(study_done),
        .hungry_cnt(hungry_cnt), .waste_cnt(waste_cnt)
    );

    kids_n #(.N(1), .STUDY_CYC(1)) dut1 (
        .clk(clk), .resetb(resetb), .meal(meal1), .book(book1),
        .request(req1), .study_done(sd1),
        .hungry_cnt(hc1), .waste_cnt(waste1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] m;
        logic [3:0] b;
        logic [3:0] req;
        logic [3:0] sd;
        logic [2:0] hc;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) ph[i] = 0;
        mwaste = 0;
        mvalid = 1'b0;
        msd    = '0;
    endtask

    task automatic model_step(input logic [3:0] m, input logic [3:0] b);
        msd = '0;
        for (int i = 0; i < N; i++) begin
            if (ph[i] == 0) begin
                if (m[i]) ph[i] = 1;
            end else if (ph[i] == 1) begin
                if (m[i]) mwaste++;
                if (b[i]) ph[i] = 2;
            end else begin
                if (m[i]) mwaste++;
                if (ph[i] - 1 == SC) begin
                    ph[i]  = 0;
                    msd[i] = 1'b1;
                end else begin
                    ph[i]++;
                end
            end
        end
        mvalid = 1'b1;
    endtask

    task automatic model_check();
        logic [3:0] er;
        int         hc;
        int         ew;
        er = '0;
        hc = 0;
        for (int i = 0; i < N; i++) begin
            if (ph[i] == 0) begin
                hc++;
                if (mvalid) er[i] = 1'b1;
            end
        end
`ifdef KIDS_WASTE_CNT_EN
        ew = (mwaste > 255) ? 255 : mwaste;
`else
        ew = 0;
`endif
        chk("model_request",    32'(request),    32'(er));
        chk("model_study_done", 32'(study_done), 32'(msd));
        chk("model_hungry_cnt", 32'(hungry_cnt), 32'(hc));
        chk("model_waste_cnt",  32'(waste_cnt),  32'(ew));
    endtask

    task automatic tick(input logic [3:0] m, input logic [3:0] b);
        meal = m;
        book = b;
        @(posedge clk);
        model_step(m, b);
        #1;
        model_check();
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        meal   = '0;
        book   = '0;
        meal1  = 1'b0;
        book1  = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        resetb = 1'b1;
        #1;
    endtask

    initial begin
        tbl[0] = '{4'b0000, 4'b0000, 4'b1111, 4'b0000, 3'd4};
        tbl[1] = '{4'b0000, 4'b1111, 4'b1111, 4'b0000, 3'd4};
        tbl[2] = '{4'b0001, 4'b0000, 4'b1110, 4'b0000, 3'd3};
        tbl[3] = '{4'b0000, 4'b0000, 4'b1110, 4'b0000, 3'd3};
        tbl[4] = '{4'b0000, 4'b0001, 4'b1110, 4'b0000, 3'd3};
        tbl[5] = '{4'b0001, 4'b0001, 4'b1110, 4'b0000, 3'd3};
        tbl[6] = '{4'b0000, 4'b0000, 4'b1110, 4'b0000, 3'd3};
        tbl[7] = '{4'b0000, 4'b0000, 4'b1111, 4'b0001, 3'd4};
        tbl[8] = '{4'b0000, 4'b0000, 4'b1111, 4'b0000, 3'd4};

        do_reset();
        chk("reset_request",    32'(request),    32'h0);
        chk("reset_study_done", 32'(study_done), 32'h0);
        chk("reset_hungry_cnt", 32'(hungry_cnt), 32'd4);
        chk("reset_waste_cnt",  32'(waste_cnt),  32'h0);

        for (int v = 0; v < 9; v++) begin
            tick(tbl[v].m, tbl[v].b);
            chk($sformatf("vec%0d_request", v),    32'(request),    32'(tbl[v].req));
            chk($sformatf("vec%0d_study_done", v), 32'(study_done), 32'(tbl[v].sd));
            chk($sformatf("vec%0d_hungry_cnt", v), 32'(hungry_cnt), 32'(tbl[v].hc));
        end

        // ch1 with meal and book together: must pass through FULL before STUDY
        begin
            int hit;
            hit = 0;
            tick(4'b0010, 4'b0010);
            chk("simul_e1_request1", 32'(request[1]), 32'h0);
            tick(4'b0010, 4'b0010);
            for (int j = 1; j <= 6; j++) begin
                tick(4'b0000, 4'b0000);
                if (study_done[1] && hit == 0) hit = j;
            end
            chk("simul_done_delay", 32'(hit), 32'(SC));
        end

        // reset asserted two cycles into STUDY on ch2
        tick(4'b0100, 4'b0000);
        tick(4'b0000, 4'b0100);
        tick(4'b0000, 4'b0000);
        #2;
        resetb = 1'b0;
        model_reset();
        #1;
        chk("midrst_request",    32'(request),    32'h0);
        chk("midrst_study_done", 32'(study_done), 32'h0);
        chk("midrst_hungry_cnt", 32'(hungry_cnt), 32'd4);
        @(negedge clk);
        resetb = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick(4'b0000, 4'b0000);
            chk("midrst_no_pulse", 32'(study_done), 32'h0);
        end

        // single channel, one study cycle
        meal1 = 1'b1;
        tick(4'b0000, 4'b0000);
        chk("n1_full_req", 32'(req1), 32'h0);
        chk("n1_full_hc",  32'(hc1),  32'h0);
        meal1 = 1'b0;
        book1 = 1'b1;
        tick(4'b0000, 4'b0000);
        chk("n1_study_req", 32'(req1), 32'h0);
        chk("n1_study_sd",  32'(sd1),  32'h0);
        book1 = 1'b0;
        tick(4'b0000, 4'b0000);
        chk("n1_done_req", 32'(req1), 32'h1);
        chk("n1_done_sd",  32'(sd1),  32'h1);
        chk("n1_done_hc",  32'(hc1),  32'h1);
        tick(4'b0000, 4'b0000);
        chk("n1_sd_once", 32'(sd1), 32'h0);

        // meals offered to full channels for 100 cycles
        do_reset();
        tick(4'b1111, 4'b0000);
        repeat (100) tick(4'b1111, 4'b0000);
`ifdef KIDS_WASTE_CNT_EN
        chk("waste_saturated", 32'(waste_cnt), 32'd255);
`else
        chk("waste_tied_zero", 32'(waste_cnt), 32'd0);
`endif
        chk("waste_all_full_hc", 32'(hungry_cnt), 32'd0);

        do_reset();
        for (int j = 0; j < 400; j++) begin
            logic [3:0] rm, rb;
            rm = 4'($urandom);
            rb = 4'($urandom);
            tick(rm, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
